// File: rtl/camera_yuv_rgb_pipe.sv
// Camera YUV 4:2:2 byte stream to RGB pixel-pair pipeline.
// Bytes collect into a macropixel, then sums are formed, then clamped out.
module camera_yuv_rgb_pipe #(
    parameter int ORDER      = 0,
    parameter int COLOR_BITS = 8,
    parameter int H_BITS     = 11,
    parameter int V_BITS     = 10
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    input  logic                  href,
    input  logic                  vsync,
    input  logic [7:0]            cam_data,
    output logic [COLOR_BITS-1:0] r0,
    output logic [COLOR_BITS-1:0] g0,
    output logic [COLOR_BITS-1:0] b0,
    output logic [COLOR_BITS-1:0] r1,
    output logic [COLOR_BITS-1:0] g1,
    output logic [COLOR_BITS-1:0] b1,
    output logic                  pair_valid,
    output logic [H_BITS-1:0]     x_pos,
    output logic [V_BITS-1:0]     y_pos,
    output logic                  frame_start,
    output logic                  line_start,
    output logic                  frame_done,
    output logic                  line_err
);

    // Packed {R,G,B}, each a signed 12-bit sum before clamping.
    function automatic logic [35:0] yuv2rgb(input logic [7:0] y,
                                            input logic [7:0] u,
                                            input logic [7:0] v);
        logic signed [11:0] yp, up, vp, r, g, b;
        yp = $signed({4'd0, y}) - 12'sd16;
        up = $signed({4'd0, u}) - 12'sd128;
        vp = $signed({4'd0, v}) - 12'sd128;
        r  = yp + vp + (vp >>> 2) + (vp >>> 3);
        g  = yp - (up >>> 2) - (up >>> 4) - (vp >>> 1) - (vp >>> 2);
        b  = yp + up + (up >>> 1) + (up >>> 2);
        return {r, g, b};
    endfunction

    function automatic logic [COLOR_BITS-1:0] clamp(input logic [11:0] s);
        logic [7:0] c;
        if (s[11])
            c = 8'd0;
        else if (s[10:8] != 3'd0)
            c = 8'hff;
        else
            c = s[7:0];
        return c[7 -: COLOR_BITS];
    endfunction

    logic [1:0]            phase_q, phase_d;
    logic [7:0]            by0_q, by0_d, by1_q, by1_d, by2_q, by2_d;
    logic                  href_q, href_d, vsync_q, vsync_d;
    logic [H_BITS-1:0]     col_q, col_d;
    logic [V_BITS-1:0]     line_q, line_d;
    logic                  has_pair_q, has_pair_d;
    logic                  frame_pend_q, frame_pend_d;

    logic                  a_vld_q, a_vld_d;
    logic [7:0]            a_y0_q, a_y0_d, a_y1_q, a_y1_d;
    logic [7:0]            a_u_q, a_u_d, a_v_q, a_v_d;
    logic [H_BITS-1:0]     a_x_q, a_x_d;
    logic [V_BITS-1:0]     a_y_q, a_y_d;
    logic                  a_fs_q, a_fs_d, a_ls_q, a_ls_d;

    logic                  s_vld_q, s_vld_d;
    logic [35:0]           s_p0_q, s_p0_d, s_p1_q, s_p1_d;
    logic [H_BITS-1:0]     s_x_q, s_x_d;
    logic [V_BITS-1:0]     s_y_q, s_y_d;
    logic                  s_fs_q, s_fs_d, s_ls_q, s_ls_d;

    logic [COLOR_BITS-1:0] r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;
    logic [COLOR_BITS-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    logic                  pv_q, pv_d;
    logic [H_BITS-1:0]     xo_q, xo_d;
    logic [V_BITS-1:0]     yo_q, yo_d;
    logic                  fs_q, fs_d, ls_q, ls_d;
    logic                  fd_q, fd_d, le_q, le_d;

    logic                  samp, href_fall, mp_done;
    logic [7:0]            y0_n, y1_n, u_n, v_n;

    assign samp      = href & ~vsync;
    assign href_fall = href_q & ~href;
    assign mp_done   = samp & (phase_q == 2'd3);

    // Byte roles within the macropixel; the fourth byte is still on cam_data.
    always_comb begin
        y0_n = by0_q;
        u_n  = by1_q;
        y1_n = by2_q;
        v_n  = cam_data;
        case (ORDER)
            1: begin
                u_n = by0_q; y0_n = by1_q; v_n = by2_q; y1_n = cam_data;
            end
            2: begin
                y0_n = by0_q; v_n = by1_q; y1_n = by2_q; u_n = cam_data;
            end
            3: begin
                v_n = by0_q; y0_n = by1_q; u_n = by2_q; y1_n = cam_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        by0_d        = by0_q;
        by1_d        = by1_q;
        by2_d        = by2_q;
        href_d       = href;
        vsync_d      = vsync;
        col_d        = col_q;
        line_d       = line_q;
        has_pair_d   = has_pair_q;
        frame_pend_d = frame_pend_q;

        if (samp) begin
            phase_d = phase_q + 2'd1;
            case (phase_q)
                2'd0:    by0_d = cam_data;
                2'd1:    by1_d = cam_data;
                2'd2:    by2_d = cam_data;
                default: ;
            endcase
        end
        if (mp_done) begin
            col_d        = col_q + H_BITS'(2);
            has_pair_d   = 1'b1;
            frame_pend_d = 1'b0;
        end
        if (href_fall) begin
            phase_d    = 2'd0;
            col_d      = '0;
            has_pair_d = 1'b0;
            if (has_pair_q)
                line_d = line_q + V_BITS'(1);
        end
        // Frame sync overrides any line-end update in the same cycle.
        if (vsync) begin
            phase_d      = 2'd0;
            col_d        = '0;
            line_d       = '0;
            has_pair_d   = 1'b0;
            frame_pend_d = 1'b1;
        end

        fd_d = vsync & ~vsync_q;
        le_d = href_fall & (phase_q != 2'd0);

        a_vld_d = mp_done;
        a_y0_d  = a_y0_q;
        a_y1_d  = a_y1_q;
        a_u_d   = a_u_q;
        a_v_d   = a_v_q;
        a_x_d   = a_x_q;
        a_y_d   = a_y_q;
        a_fs_d  = a_fs_q;
        a_ls_d  = a_ls_q;
        if (mp_done) begin
            a_y0_d = y0_n;
            a_y1_d = y1_n;
            a_u_d  = u_n;
            a_v_d  = v_n;
            a_x_d  = col_q;
            a_y_d  = line_q;
            a_fs_d = frame_pend_q;
            a_ls_d = ~has_pair_q;
        end

        s_vld_d = a_vld_q;
        s_p0_d  = s_p0_q;
        s_p1_d  = s_p1_q;
        s_x_d   = s_x_q;
        s_y_d   = s_y_q;
        s_fs_d  = s_fs_q;
        s_ls_d  = s_ls_q;
        if (a_vld_q) begin
            s_p0_d = yuv2rgb(a_y0_q, a_u_q, a_v_q);
            s_p1_d = yuv2rgb(a_y1_q, a_u_q, a_v_q);
            s_x_d  = a_x_q;
            s_y_d  = a_y_q;
            s_fs_d = a_fs_q;
            s_ls_d = a_ls_q;
        end

        pv_d = s_vld_q;
        r0_d = r0_q;
        g0_d = g0_q;
        b0_d = b0_q;
        r1_d = r1_q;
        g1_d = g1_q;
        b1_d = b1_q;
        xo_d = xo_q;
        yo_d = yo_q;
        fs_d = 1'b0;
        ls_d = 1'b0;
        if (s_vld_q) begin
            r0_d = clamp(s_p0_q[35:24]);
            g0_d = clamp(s_p0_q[23:12]);
            b0_d = clamp(s_p0_q[11:0]);
            r1_d = clamp(s_p1_q[35:24]);
            g1_d = clamp(s_p1_q[23:12]);
            b1_d = clamp(s_p1_q[11:0]);
            xo_d = s_x_q;
            yo_d = s_y_q;
            fs_d = s_fs_q;
            ls_d = s_ls_q;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= '0;
            by0_q        <= '0;
            by1_q        <= '0;
            by2_q        <= '0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            has_pair_q   <= 1'b0;
            frame_pend_q <= 1'b0;
            a_vld_q      <= 1'b0;
            a_y0_q       <= '0;
            a_y1_q       <= '0;
            a_u_q        <= '0;
            a_v_q        <= '0;
            a_x_q        <= '0;
            a_y_q        <= '0;
            a_fs_q       <= 1'b0;
            a_ls_q       <= 1'b0;
            s_vld_q      <= 1'b0;
            s_p0_q       <= '0;
            s_p1_q       <= '0;
            s_x_q        <= '0;
            s_y_q        <= '0;
            s_fs_q       <= 1'b0;
            s_ls_q       <= 1'b0;
            pv_q         <= 1'b0;
            r0_q         <= '0;
            g0_q         <= '0;
            b0_q         <= '0;
            r1_q         <= '0;
            g1_q         <= '0;
            b1_q         <= '0;
            xo_q         <= '0;
            yo_q         <= '0;
            fs_q         <= 1'b0;
            ls_q         <= 1'b0;
            fd_q         <= 1'b0;
            le_q         <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            by0_q        <= by0_d;
            by1_q        <= by1_d;
            by2_q        <= by2_d;
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            col_q        <= col_d;
            line_q       <= line_d;
            has_pair_q   <= has_pair_d;
            frame_pend_q <= frame_pend_d;
            a_vld_q      <= a_vld_d;
            a_y0_q       <= a_y0_d;
            a_y1_q       <= a_y1_d;
            a_u_q        <= a_u_d;
            a_v_q        <= a_v_d;
            a_x_q        <= a_x_d;
            a_y_q        <= a_y_d;
            a_fs_q       <= a_fs_d;
            a_ls_q       <= a_ls_d;
            s_vld_q      <= s_vld_d;
            s_p0_q       <= s_p0_d;
            s_p1_q       <= s_p1_d;
            s_x_q        <= s_x_d;
            s_y_q        <= s_y_d;
            s_fs_q       <= s_fs_d;
            s_ls_q       <= s_ls_d;
            pv_q         <= pv_d;
            r0_q         <= r0_d;
            g0_q         <= g0_d;
            b0_q         <= b0_d;
            r1_q         <= r1_d;
            g1_q         <= g1_d;
            b1_q         <= b1_d;
            xo_q         <= xo_d;
            yo_q         <= yo_d;
            fs_q         <= fs_d;
            ls_q         <= ls_d;
            fd_q         <= fd_d;
            le_q         <= le_d;
        end
    end

    assign r0          = r0_q;
    assign g0          = g0_q;
    assign b0          = b0_q;
    assign r1          = r1_q;
    assign g1          = g1_q;
    assign b1          = b1_q;
    assign pair_valid  = pv_q;
    assign x_pos       = xo_q;
    assign y_pos       = yo_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign frame_done  = fd_q;
    assign line_err    = le_q;

endmodule

// File: tb/tb_camera_yuv_rgb_pipe.sv
// Directed bench: three pipe instances (ORDER 0 / ORDER 1 / 5-bit colour)
// share one camera stream; expected values are hand-computed.
module tb_camera_yuv_rgb_pipe;

    logic       pclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       href = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] cam_data = 8'd0;

    int total = 0;
    int bad = 0;

    logic [7:0]  a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;
    logic        a_pv, a_fs, a_ls, a_fd, a_le;
    logic [10:0] a_x;
    logic [9:0]  a_y;

    logic [7:0]  b_r0, b_g0, b_b0, b_r1, b_g1, b_b1;
    logic        b_pv, b_fs, b_ls, b_fd, b_le;
    logic [10:0] b_x;
    logic [9:0]  b_y;

    logic [4:0]  c_r0, c_g0, c_b0, c_r1, c_g1, c_b1;
    logic        c_pv, c_fs, c_ls, c_fd, c_le;
    logic [10:0] c_x;
    logic [9:0]  c_y;

    always #5 pclk = ~pclk;

    camera_yuv_rgb_pipe #(.ORDER(0), .COLOR_BITS(8)) u0 (
        .pclk(pclk), .reset_n(reset_n), .href(href), .vsync(vsync),
        .cam_data(cam_data),
        .r0(a_r0), .g0(a_g0), .b0(a_b0), .r1(a_r1), .g1(a_g1), .b1(a_b1),
        .pair_valid(a_pv), .x_pos(a_x), .y_pos(a_y),
        .frame_start(a_fs), .line_start(a_ls),
        .frame_done(a_fd), .line_err(a_le)
    );

    camera_yuv_rgb_pipe #(.ORDER(1), .COLOR_BITS(8)) u1 (
        .pclk(pclk), .reset_n(reset_n), .href(href), .vsync(vsync),
        .cam_data(cam_data),
        .r0(b_r0), .g0(b_g0), .b0(b_b0), .r1(b_r1), .g1(b_g1), .b1(b_b1),
        .pair_valid(b_pv), .x_pos(b_x), .y_pos(b_y),
        .frame_start(b_fs), .line_start(b_ls),
        .frame_done(b_fd), .line_err(b_le)
    );

    camera_yuv_rgb_pipe #(.ORDER(0), .COLOR_BITS(5)) u2 (
        .pclk(pclk), .reset_n(reset_n), .href(href), .vsync(vsync),
        .cam_data(cam_data),
        .r0(c_r0), .g0(c_g0), .b0(c_b0), .r1(c_r1), .g1(c_g1), .b1(c_b1),
        .pair_valid(c_pv), .x_pos(c_x), .y_pos(c_y),
        .frame_start(c_fs), .line_start(c_ls),
        .frame_done(c_fd), .line_err(c_le)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        href = 1'b1;
        vsync = 1'b0;
        cam_data = b;
        @(posedge pclk);
        #1;
    endtask

    task automatic push4(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3);
        push(p0);
        push(p1);
        push(p2);
        push(p3);
    endtask

    task automatic idle();
        href = 1'b0;
        vsync = 1'b0;
        cam_data = 8'd0;
        @(posedge pclk);
        #1;
    endtask

    task automatic vs();
        href = 1'b0;
        vsync = 1'b1;
        cam_data = 8'd0;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_pv", a_pv, 0);
        chk("rst_r0", a_r0, 0);
        chk("rst_x", a_x, 0);
        chk("rst_y", a_y, 0);
        chk("rst_fs", a_fs, 0);
        @(posedge pclk);
        #1;
        reset_n = 1'b1;
        idle();
        idle();

        // frame sync pulse
        vs();
        chk("fd_pulse", a_fd, 1);
        vs();
        chk("fd_one_cycle", a_fd, 0);
        idle();

        // black pair, latency, first-of-frame flags
        push4(8'd16, 8'd128, 8'd16, 8'd128);
        idle();
        chk("lat_early", a_pv, 0);
        idle();
        chk("lat_pv", a_pv, 1);
        chk("blk_r0", a_r0, 0);
        chk("blk_g0", a_g0, 0);
        chk("blk_b1", a_b1, 0);
        chk("blk_x", a_x, 0);
        chk("blk_y", a_y, 0);
        chk("blk_fs", a_fs, 1);
        chk("blk_ls", a_ls, 1);
        idle();
        chk("pv_strobe", a_pv, 0);
        chk("fs_strobe", a_fs, 0);

        // ORDER=1: U Y0 V Y1
        push4(8'd128, 8'd235, 8'd128, 8'd235);
        idle();
        idle();
        chk("o1_pv", b_pv, 1);
        chk("o1_r0", b_r0, 219);
        chk("o1_g0", b_g0, 219);
        chk("o1_b0", b_b0, 219);
        chk("o1_r1", b_r1, 219);
        chk("o1_g1", b_g1, 219);
        chk("o1_b1", b_b1, 219);
        chk("o1_y", b_y, 1);
        chk("o1_fs", b_fs, 0);

        push4(8'd128, 8'd255, 8'd255, 8'd255);
        idle();
        idle();
        chk("rclamp_r0", b_r0, 255);
        chk("rclamp_g0", b_g0, 145);
        chk("rclamp_b0", b_b0, 239);
        chk("rclamp_r1", b_r1, 255);

        push4(8'd0, 8'd16, 8'd128, 8'd16);
        idle();
        idle();
        chk("bclamp_b0", b_b0, 0);
        chk("bclamp_r0", b_r0, 0);
        chk("bclamp_g0", b_g0, 40);
        chk("bclamp_b1", b_b1, 0);

        // 5-bit colour and 8-bit reference
        push4(8'd200, 8'd128, 8'd200, 8'd128);
        idle();
        idle();
        chk("cb5_r0", c_r0, 23);
        chk("cb5_g1", c_g1, 23);
        chk("cb5_b0", c_b0, 23);
        chk("cb8_r0", a_r0, 184);
        chk("cb8_y", a_y, 4);

        // six-byte line ends mid-macropixel
        push4(8'd16, 8'd128, 8'd16, 8'd128);
        push(8'd16);
        push(8'd128);
        chk("l6_pv", a_pv, 1);
        chk("l6_x", a_x, 0);
        chk("l6_y", a_y, 5);
        idle();
        chk("l6_err", a_le, 1);
        chk("l6_nopv", a_pv, 0);
        idle();
        chk("l6_err_clr", a_le, 0);
        chk("l6_discard", a_pv, 0);

        // eight-byte line, back-to-back pairs
        push4(8'd235, 8'd128, 8'd235, 8'd128);
        push(8'd16);
        push(8'd128);
        chk("l8a_pv", a_pv, 1);
        chk("l8a_x", a_x, 0);
        chk("l8a_y", a_y, 6);
        chk("l8a_ls", a_ls, 1);
        chk("l8a_r0", a_r0, 219);
        push(8'd16);
        chk("l8_gap", a_pv, 0);
        chk("l8_hold", a_r0, 219);
        push(8'd128);
        idle();
        idle();
        chk("l8b_pv", a_pv, 1);
        chk("l8b_x", a_x, 2);
        chk("l8b_ls", a_ls, 0);
        chk("l8b_r0", a_r0, 0);
        chk("l8b_err", a_le, 0);

        // vsync while a pair is in flight
        push4(8'd235, 8'd128, 8'd235, 8'd128);
        vs();
        chk("mid_fd", a_fd, 1);
        chk("mid_pv0", a_pv, 0);
        vs();
        chk("mid_pv", a_pv, 1);
        chk("mid_y", a_y, 7);
        chk("mid_fs", a_fs, 0);
        idle();
        push4(8'd200, 8'd128, 8'd200, 8'd128);
        idle();
        idle();
        chk("nf_pv", a_pv, 1);
        chk("nf_y", a_y, 0);
        chk("nf_x", a_x, 0);
        chk("nf_fs", a_fs, 1);
        chk("nf_r0", a_r0, 184);

        // reset between bytes 2 and 3
        push(8'd235);
        push(8'd128);
        reset_n = 1'b0;
        href = 1'b0;
        #1;
        chk("mr_r0", a_r0, 0);
        chk("mr_b1", a_b1, 0);
        chk("mr_pv", a_pv, 0);
        @(posedge pclk);
        #1;
        reset_n = 1'b1;
        push(8'd16);
        push(8'd128);
        idle();
        chk("mr_err", a_le, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("mr_nopv", a_pv, 0);
        end
        push4(8'd235, 8'd128, 8'd235, 8'd128);
        idle();
        idle();
        chk("mr_pv_new", a_pv, 1);
        chk("mr_r0_new", a_r0, 219);
        chk("mr_fs", a_fs, 0);
        chk("mr_y", a_y, 0);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
